// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the run-time clock divider controller.
package div_ctrl_pkg;

    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned DEF_DIV   = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/div_core.sv
// Divider core: half-period counter, registered divided clock and rise tick.
// fall_c flags the cycle whose edge turns div_clk 1->0 (ratio swap point).
module div_core
    import div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic [CNT_W-1:0] div,
    output logic             div_clk,
    output logic             tick,
    output logic             fall_c
);

    logic [CNT_W-1:0] k;
    logic             toggle_c;

    assign toggle_c = cnt_en && (k >= div);
    assign fall_c   = toggle_c && div_clk;

    // Disabled counting parks the divider at k=0 with the clock low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else if (!cnt_en) begin
            k       <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else if (toggle_c) begin
            k       <= '0;
            div_clk <= ~div_clk;
            tick    <= ~div_clk;
        end else begin
            k       <= k + CNT_W'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/div_sched_ctrl.sv
// Run/stop sequencing and ratio handshake for the programmable clock divider.
// Optional period counter output enabled by defining DIVCTL_PERIOD_CNT_EN.
module div_sched_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             I_CLK,
    input  logic             Rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             O_CLK,
    output logic             tick,
    output logic             busy,
`ifdef DIVCTL_PERIOD_CNT_EN
    output logic [CNT_W-1:0] cur_div,
    output logic [15:0]      period_cnt
`else
    output logic [CNT_W-1:0] cur_div
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic             cnt_en_c;
    logic             fall_c;
    logic             stop_exit_c;
    logic             accept_c;
    logic             direct_c;
    logic             apply_c;
    logic             pend_vld;
    logic             pend_vld_nxt;
    logic [CNT_W-1:0] pend_div;

    // Count in RUN; in STOP only while finishing a high phase or resuming.
    assign cnt_en_c = (state == RUN) || ((state == STOP) && (en || O_CLK));

    div_core #(
        .CNT_W   (CNT_W)
    ) u_core (
        .clk     (I_CLK),
        .rst     (Rst),
        .cnt_en  (cnt_en_c),
        .div     (cur_div),
        .div_clk (O_CLK),
        .tick    (tick),
        .fall_c  (fall_c)
    );

    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        stop_exit_c = 1'b0;
        case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN:  if (!en) state_nxt = STOP;
            STOP: begin
                if (en) begin
                    state_nxt = RUN;
                end else if (!O_CLK || fall_c) begin
                    state_nxt   = IDLE;
                    stop_exit_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ratios land directly only while the output is parked low.
    assign accept_c     = cfg_valid && cfg_ready;
    assign direct_c     = (state == IDLE) || ((state == STOP) && !O_CLK);
    assign apply_c      = pend_vld && (fall_c || stop_exit_c);
    assign pend_vld_nxt = (accept_c && !direct_c) || (pend_vld && !apply_c);

    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            cur_div   <= CNT_W'(DEFAULT_DIV);
            pend_div  <= '0;
            pend_vld  <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            pend_vld  <= pend_vld_nxt;
            cfg_ready <= ~pend_vld_nxt;
            busy      <= (state_nxt != IDLE);
            if (accept_c && direct_c) cur_div <= cfg_div;
            else if (apply_c)         cur_div <= pend_div;
            if (accept_c && !direct_c) pend_div <= cfg_div;
        end
    end

`ifdef DIVCTL_PERIOD_CNT_EN
    logic load_c;
    assign load_c = (accept_c && direct_c) || apply_c;

    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst)         period_cnt <= '0;
        else if (load_c) period_cnt <= '0;
        else if (fall_c) period_cnt <= period_cnt + 16'(1);
    end
`endif

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Scoreboard bench for div_sched_ctrl: expected O_CLK edges queued by stimulus,
// checked by a negedge monitor; handshake and status checked inline.
module tb_div_sched_ctrl;

    localparam int unsigned CNT_W = 16;

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    logic             I_CLK = 1'b0;
    logic             Rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             O_CLK;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] cur_div;
`ifdef DIVCTL_PERIOD_CNT_EN
    logic [15:0]      period_cnt;
`endif

    int   nvec = 0;
    int   nbad = 0;
    int   cyc  = 0;
    ev_t  exp_q[$];
    logic prev = 1'b0;

    div_sched_ctrl dut (
        .I_CLK      (I_CLK),
        .Rst        (Rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .O_CLK      (O_CLK),
        .tick       (tick),
        .busy       (busy),
`ifdef DIVCTL_PERIOD_CNT_EN
        .cur_div    (cur_div),
        .period_cnt (period_cnt)
`else
        .cur_div    (cur_div)
`endif
    );

    always #5 I_CLK = ~I_CLK;
    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic l);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 1000 && cyc < c; i++) begin
            @(posedge I_CLK);
            #1;
        end
    endtask

    // Offer a ratio and hold it until transferred; returns the transfer cycle.
    task automatic send_cfg(input logic [CNT_W-1:0] d, output int xcyc);
        logic rdy;
        xcyc      = -1;
        cfg_valid = 1'b1;
        cfg_div   = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge I_CLK);
            rdy = cfg_ready;
            @(posedge I_CLK);
            #1;
            if (rdy) begin
                xcyc = cyc;
                break;
            end
        end
        cfg_valid = 1'b0;
        if (xcyc < 0) begin
            nvec++;
            nbad++;
            $display("FAIL cfg_timeout: ratio %0d never accepted", d);
        end
    endtask

    // Monitor: every O_CLK change must match the next queued edge.
    always @(negedge I_CLK) begin
        logic rise;
        ev_t  e;
        rise = O_CLK && !prev;
        if (O_CLK !== prev) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nbad++;
                $display("FAIL unexpected_edge: O_CLK went %0b at cyc %0d, none expected", O_CLK, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.lvl !== O_CLK) begin
                    nbad++;
                    $display("FAIL edge: got lvl %0b at cyc %0d expected lvl %0b at cyc %0d",
                             O_CLK, cyc, e.lvl, e.cyc);
                end
            end
        end
        if (rise || tick) begin
            nvec++;
            if (tick !== rise) begin
                nbad++;
                $display("FAIL tick: got %0b expected %0b at cyc %0d", tick, rise, cyc);
            end
        end
        prev = O_CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, x;
        Rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #2 Rst = 1'b1;
        repeat (3) @(posedge I_CLK);
        #1 Rst = 1'b0;
        chk("rst_o_clk",     32'(O_CLK),     32'd0);
        chk("rst_tick",      32'(tick),      32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cur_div",   32'(cur_div),   32'd20);

        // Default ratio 20: rise 22 after en set, half period 21.
        t0 = cyc;
        en = 1'b1;
        push_ev(t0 + 22, 1'b1); push_ev(t0 + 43, 1'b0);
        push_ev(t0 + 64, 1'b1); push_ev(t0 + 85, 1'b0);
        push_ev(t0 + 90, 1'b1); push_ev(t0 + 95, 1'b0);
        push_ev(t0 + 103, 1'b1); push_ev(t0 + 111, 1'b0);
        push_ev(t0 + 119, 1'b1); push_ev(t0 + 127, 1'b0);

        // Ratio 4 offered mid high phase: pending until the fall at t0+85.
        wait_until(t0 + 70);
        send_cfg(16'd4, x);
        chk("xfer4_cyc",       32'(x),         32'(t0 + 71));
        chk("pend4_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("pend4_cur_div",   32'(cur_div),   32'd20);
        // Ratio 7 back-pressured until one cycle after the apply.
        send_cfg(16'd7, x);
        chk("xfer7_cyc",       32'(x),         32'(t0 + 86));
        chk("apply4_cur_div",  32'(cur_div),   32'd4);
        chk("pend7_cfg_ready", 32'(cfg_ready), 32'd0);
        wait_until(t0 + 96);
        chk("apply7_cur_div",  32'(cur_div),   32'd7);
        chk("apply7_ready",    32'(cfg_ready), 32'd1);

        // Stop during high phase: the phase completes, then idle.
        wait_until(t0 + 122);
        en = 1'b0;
        wait_until(t0 + 123);
        chk("stop_busy",     32'(busy),  32'd1);
        wait_until(t0 + 128);
        chk("idle_busy",     32'(busy),  32'd0);
        chk("idle_o_clk",    32'(O_CLK), 32'd0);
        wait_until(t0 + 160);
        chk("idle_hold_clk", 32'(O_CLK), 32'd0);

        // Ratio 0 loaded in IDLE: toggles every cycle.
        t1 = cyc;
        send_cfg(16'd0, x);
        chk("xfer0_cyc",    32'(x),         32'(t1 + 1));
        chk("div0_cur_div", 32'(cur_div),   32'd0);
        chk("div0_ready",   32'(cfg_ready), 32'd1);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_ev(t1 + 3 + 2 * i, 1'b1);
            push_ev(t1 + 4 + 2 * i, 1'b0);
        end
        wait_until(t1 + 8);
        en = 1'b0;
        wait_until(t1 + 11);
        chk("div0_idle_busy", 32'(busy),  32'd0);
        chk("div0_idle_clk",  32'(O_CLK), 32'd0);

        // Reset mid high phase with a pending ratio.
        wait_until(t1 + 20);
        t2 = cyc;
        send_cfg(16'd3, x);
        en = 1'b1;
        push_ev(t2 + 6, 1'b1); push_ev(t2 + 10, 1'b0);
        push_ev(t2 + 14, 1'b1); push_ev(t2 + 17, 1'b0);
        wait_until(t2 + 15);
        send_cfg(16'd9, x);
        chk("xfer9_cyc",    32'(x),         32'(t2 + 16));
        chk("pend9_ready",  32'(cfg_ready), 32'd0);
        chk("pend9_curdiv", 32'(cur_div),   32'd3);
        wait_until(t2 + 17);
        Rst = 1'b1;
        #1;
        chk("async_rst_clk", 32'(O_CLK), 32'd0);
        en = 1'b0;
        repeat (2) @(posedge I_CLK);
        #1 Rst = 1'b0;
        @(posedge I_CLK);
        #1;
        chk("post_rst_cur_div", 32'(cur_div),   32'd20);
        chk("post_rst_ready",   32'(cfg_ready), 32'd1);
        chk("post_rst_busy",    32'(busy),      32'd0);
        chk("post_rst_clk",     32'(O_CLK),     32'd0);
        chk("post_rst_tick",    32'(tick),      32'd0);
        repeat (10) @(posedge I_CLK);
        #1;
        chk("edges_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/div_sched_ctrl.md
Name: div_sched_ctrl

Overview:
- Run-time controller for the programmable clock divider.
- Accepts divide ratios over a valid/ready config port and sequences start and stop of the divided output.
- Swaps ratios only at full-period boundaries, so O_CLK never produces a runt pulse.
- Sits between the system config/control logic and every consumer of the divided clock-enable or toggle output.

Parameters:
- CNT_W, 16, width of the divide ratio and the internal counter.
- DEFAULT_DIV, 20, ratio loaded at reset; must fit in CNT_W bits.

Ports:
- I_CLK  in  1  system clock; all logic on posedge.
- Rst  in  1  reset, asynchronous, active-high.
- en  in  1  level; 1 = run divider, 0 = stop at next low phase.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  CNT_W  ratio; half period = cfg_div+1 I_CLK cycles.
- cfg_ready  out  1  controller can accept a ratio this cycle.
- O_CLK  out  1  divided clock, registered.
- tick  out  1  1-cycle pulse on every O_CLK rising toggle.
- busy  out  1  state != IDLE.
- cur_div  out  CNT_W  ratio currently in effect.

Behaviour:
- Reset values (async on Rst=1):
  - state=IDLE, k=0, O_CLK=0, tick=0.
  - cur_div=DEFAULT_DIV, pend_vld=0, cfg_ready=1.
- Counter rule, identical to the existing divider:
  - In RUN/STOP each cycle: if k>=cur_div then O_CLK toggles and k<=0; else k<=k+1.
  - Full period = 2*(cur_div+1) cycles. cur_div=0 gives O_CLK toggling every cycle.
- tick=1 in the cycle following a 0->1 toggle (registered alongside O_CLK).
- States:
  - IDLE:
    - k held 0, O_CLK=0.
    - en=1 -> RUN; first toggle occurs cur_div+1 cycles after entry.
  - RUN:
    - Counting.
    - en=0 -> STOP.
    - A 1->0 toggle with pend_vld=1 applies the pending ratio: cur_div<=pend_div, pend_vld<=0 in the same cycle, and counting restarts at k=0 with the new ratio.
  - STOP:
    - Keeps counting until the next 1->0 toggle, or stops immediately if O_CLK=0 on entry; then -> IDLE.
    - A pending ratio is applied on that exit edge.
    - en=1 during STOP -> back to RUN with no phase disturbance.
- Config handshake:
  - cfg_ready = ~pend_vld.
  - Transfer when cfg_valid & cfg_ready.
  - In IDLE, or in STOP with O_CLK=0 on entry, the ratio goes directly to cur_div next cycle. Otherwise pend_div<=cfg_div, pend_vld<=1.
  - A second ratio while pending is back-pressured (cfg_ready=0). The requester must hold cfg_valid/cfg_div until accepted.
- Simultaneous events:
  - Acceptance and apply in the same cycle: the apply uses the old pending value; the new value becomes pending.
  - en falling and a toggle in the same cycle: the toggle completes, then STOP.
- cfg_div is unsigned, no saturation. k is CNT_W bits and never exceeds cur_div, so there is no wrap.
- Rst mid-period: O_CLK forced to 0 asynchronously; a pending ratio is discarded.

Optional Feature:
- Macro DIVCTL_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt[15:0], reset 0.
  - Increments on each 1->0 toggle and wraps 0xFFFF->0.
  - Cleared when a new ratio is applied.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package div_ctrl_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, STOP=2'd2);
  - CNT_W default;
  - DEFAULT_DIV constant.
- One natural sub-module, div_core: counter k, O_CLK toggle, tick, and a load strobe for cur_div. The controller FSM and config handshake stay in div_sched_ctrl.

Test Plan:
- Reset then en=1, DEFAULT_DIV=20 -> first O_CLK rise 21 cycles after RUN entry; period 42 cycles; tick pulses every 42 cycles.
- In RUN with div=20, send cfg_div=4 mid-high-phase -> accepted, cfg_ready=0 until the next falling toggle; subsequent period = 10 cycles; no half-phase shorter than 5.
- Pending held; send a second ratio 7 -> cfg_ready stays 0, no transfer; after apply, 7 accepted and pending.
- en=0 while O_CLK=1 -> high phase completes at full length, O_CLK=0, busy=0 one cycle after that fall; O_CLK stays 0.
- cfg_div=0 in IDLE, then en=1 -> O_CLK toggles every cycle, period 2.
- Assert Rst mid-high-phase with a pending ratio -> O_CLK=0 immediately; cur_div=20 and pend_vld=0 after release.
